// File: rtl/etx_protocol.sv
// Elink transmit framer: accepts one eMesh transaction per handshake and
// serialises it as a 14-byte frame, one byte per clock, toward the DDR serializer.
module etx_protocol #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned GAP = 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          etx_access,
  input  logic          etx_write,
  input  logic [1:0]    etx_datamode,
  input  logic [3:0]    etx_ctrlmode,
  input  logic [AW-1:0] etx_dstaddr,
  input  logic [DW-1:0] etx_data,
  input  logic [AW-1:0] etx_srcaddr,
  output logic          etx_ack,
  input  logic          tx_wr_wait,
  input  logic          tx_rd_wait,
  input  logic          ecfg_tx_enable,
  input  logic          ecfg_tx_force_mode,
  input  logic [8:0]    ecfg_tx_force_data,
  output logic          tx_frame,
  output logic [7:0]    tx_data,
  output logic          tx_busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_BYTE = CW'(13);
  // The IDLE cycle carrying the next ack is itself a frame-low cycle, so the
  // GAP state only has to cover the remaining GAP-1 idle cycles.
  localparam logic [CW-1:0] GAP_LAST = (GAP > 1) ? CW'(GAP - 2) : CW'(0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            frame_q;
  logic [7:0]      data_q;
  logic            busy_q;

  logic            pkt_write_q;
  logic [1:0]      pkt_dm_q;
  logic [3:0]      pkt_ctrl_q;
  logic [AW-1:0]   pkt_dst_q;
  logic [DW-1:0]   pkt_data_q;
  logic [AW-1:0]   pkt_src_q;

  logic [CW-1:0]   nxt_idx;
  logic [7:0]      byte_d;
  logic            wait_sel;

  // Pushback relevant to the offered transaction's direction
  assign wait_sel = etx_write ? tx_wr_wait : tx_rd_wait;
  assign etx_ack  = ~reset & (state_q == S_IDLE) & etx_access & ecfg_tx_enable
                    & ~ecfg_tx_force_mode & ~wait_sel;

  assign nxt_idx  = cnt_q + CW'(1);

  // Byte map: selects the byte to be presented on the next cycle
  always_comb begin
    byte_d = 8'h00;
    case (nxt_idx)
      4'd1:    byte_d = {pkt_ctrl_q, pkt_dst_q[31:28]};
      4'd2:    byte_d = pkt_dst_q[27:20];
      4'd3:    byte_d = pkt_dst_q[19:12];
      4'd4:    byte_d = pkt_dst_q[11:4];
      4'd5:    byte_d = {pkt_dst_q[3:0], pkt_dm_q, pkt_write_q, 1'b1};
      4'd6:    byte_d = pkt_data_q[31:24];
      4'd7:    byte_d = pkt_data_q[23:16];
      4'd8:    byte_d = pkt_data_q[15:8];
      4'd9:    byte_d = pkt_data_q[7:0];
      4'd10:   byte_d = pkt_src_q[31:24];
      4'd11:   byte_d = pkt_src_q[23:16];
      4'd12:   byte_d = pkt_src_q[15:8];
      4'd13:   byte_d = pkt_src_q[7:0];
      default: byte_d = 8'h00;
    endcase
  end

  // Framer FSM with registered outputs and packet capture
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      frame_q     <= 1'b0;
      data_q      <= 8'h00;
      busy_q      <= 1'b0;
      pkt_write_q <= 1'b0;
      pkt_dm_q    <= '0;
      pkt_ctrl_q  <= '0;
      pkt_dst_q   <= '0;
      pkt_data_q  <= '0;
      pkt_src_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (etx_ack) begin
            pkt_write_q <= etx_write;
            pkt_dm_q    <= etx_datamode;
            pkt_ctrl_q  <= etx_ctrlmode;
            pkt_dst_q   <= etx_dstaddr;
            pkt_data_q  <= etx_data;
            pkt_src_q   <= etx_srcaddr;
            state_q     <= S_SEND;
            frame_q     <= 1'b1;
            data_q      <= 8'h00;
            busy_q      <= 1'b1;
          end else if (ecfg_tx_force_mode) begin
            frame_q <= ecfg_tx_force_data[8];
            data_q  <= ecfg_tx_force_data[7:0];
            busy_q  <= 1'b0;
          end else begin
            frame_q <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
          end
        end
        S_SEND: begin
          if (cnt_q == LAST_BYTE) begin
            cnt_q   <= '0;
            frame_q <= 1'b0;
            data_q  <= 8'h00;
            if (GAP > 1) begin
              state_q <= S_GAP;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q   <= nxt_idx;
            frame_q <= 1'b1;
            data_q  <= byte_d;
            busy_q  <= 1'b1;
          end
        end
        S_GAP: begin
          frame_q <= 1'b0;
          data_q  <= 8'h00;
          if (cnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= nxt_idx;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          frame_q <= 1'b0;
          data_q  <= 8'h00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_frame = frame_q;
  assign tx_data  = data_q;
  assign tx_busy  = busy_q;

endmodule
